core_muldiv: RTL and testbench

- Iterative, parametrised RV32M/RV64M multiply/divide unit.
- Sits beside the single-cycle integer ALU in the EX stage and handles OP opcode 0110011 with funct7=0000001.
- The pipeline stalls on o_busy and captures o_res on the o_done pulse.
- STEP_BITS sets how many product or quotient bits are produced per cycle, trading area for latency.

---
 rtl/core_pkg.sv | 49 ++++
 rtl/core_muldiv_step.sv | 58 +++++
 rtl/core_muldiv.sv | 162 ++++++++++++++++
 tb/tb_core_muldiv.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the integer core.
//   - OPCODE_OP / FUNCT7_MULDIV identify the RV32M/RV64M group so the decoder
//     can route those instructions to core_muldiv instead of the ALU.
//   - muldiv_op_t mirrors funct3 of the M-extension instructions.
//   - muldiv_state_t is the multiply/divide sequencer state.
//   - rs1_signed / rs2_signed tell which operands are treated as two's complement.
package core_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } muldiv_state_t;

    // MUL produces only the low half, which is sign-agnostic, so it is unsigned here.
    function automatic logic rs1_signed(input muldiv_op_t op);
        logic s;
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
            default:                            s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic rs2_signed(input muldiv_op_t op);
        logic s;
        case (op)
            OP_MULH, OP_DIV, OP_REM: s = 1'b1;
            default:                 s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/core_muldiv_step.sv
// core_muldiv_step: one iteration of the multiply/divide datapath (combinational).
//   mode_div  : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_hi    : XLEN+1 bits; product high half (multiply) or partial remainder (divide)
//   acc_lo    : XLEN bits; multiplier bits still to consume plus product low bits
//               (multiply), or dividend bits still to consume plus quotient bits (divide)
//   opnd      : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   nxt_hi/lo : accumulator after STEP_BITS single-bit steps
module core_muldiv_step #(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  logic            mode_div,
    input  logic [XLEN:0]   acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN:0]   nxt_hi,
    output logic [XLEN-1:0] nxt_lo
);

    logic [XLEN:0]   hi_s;
    logic [XLEN-1:0] lo_s;
    logic [XLEN:0]   sum_s;
    logic [XLEN:0]   shf_s;
    logic [XLEN+1:0] diff_s;

    // Unrolled chain of STEP_BITS single-bit multiply or divide steps.
    always_comb begin
        hi_s   = acc_hi;
        lo_s   = acc_lo;
        sum_s  = {(XLEN+1){1'b0}};
        shf_s  = {(XLEN+1){1'b0}};
        diff_s = {(XLEN+2){1'b0}};
        for (int i = 0; i < STEP_BITS; i++) begin
            if (mode_div) begin
                // Bring the next dividend bit into the remainder and try to subtract.
                shf_s  = {hi_s[XLEN-1:0], lo_s[XLEN-1]};
                diff_s = {1'b0, shf_s} - {2'b00, opnd};
                if (diff_s[XLEN+1] == 1'b0) begin
                    hi_s = diff_s[XLEN:0];
                    lo_s = {lo_s[XLEN-2:0], 1'b1};
                end else begin
                    hi_s = shf_s;
                    lo_s = {lo_s[XLEN-2:0], 1'b0};
                end
            end else begin
                // Add multiplicand if the current multiplier LSB is set, then shift
                // the whole accumulator right; product bits fill in from the top of lo.
                sum_s = {1'b0, hi_s[XLEN-1:0]} +
                        (lo_s[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
                hi_s  = {1'b0, sum_s[XLEN:1]};
                lo_s  = {sum_s[0], lo_s[XLEN-1:1]};
            end
        end
        nxt_hi = hi_s;
        nxt_lo = lo_s;
    end

endmodule

// File: rtl/core_muldiv.sv
// core_muldiv: iterative RV32M/RV64M multiply/divide unit for the EX stage.
//   clk, rst          : clock, asynchronous active-high reset
//   i_start, i_funct3 : request and M-extension funct3 (sampled in IDLE or DONE)
//   i_num1u, i_num2u  : rs1 / rs2 values
//   i_flush           : abandon the current operation
//   o_busy            : high in CALC and FIX; pipeline stalls
//   o_done            : one-cycle pulse in DONE; o_res valid
//   o_res             : result, held until a new result is produced
// Latency is XLEN/STEP_BITS + 2 cycles; divide-by-zero and signed overflow
// are resolved at accept time and finish in one cycle.
module core_muldiv
    import core_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_num1u,
    input  logic [XLEN-1:0] i_num2u,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_res
);

    localparam int              N_ITER   = XLEN / STEP_BITS;
    localparam int              CNT_W    = $clog2(N_ITER + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_ITER);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t   state_r, state_nxt_s;
    muldiv_op_t      op_r, op_in_s;
    logic            sign1_r, sign2_r, busy_r, done_r;
    logic [CNT_W-1:0] cnt_r;
    logic [XLEN:0]   hi_r, step_hi_s;
    logic [XLEN-1:0] lo_r, opnd_r, res_r, step_lo_s;

    logic            accept_s, is_div_s, sign1_s, sign2_s;
    logic            div_zero_s, ovf_s, special_s;
    logic [XLEN-1:0] mag1_s, mag2_s, special_res_s, fix_res_s, quo_s, rem_s;
    logic [2*XLEN-1:0] prod_s;

    core_muldiv_step #(.XLEN(XLEN), .STEP_BITS(STEP_BITS)) u_step (
        .mode_div (op_r[2]),
        .acc_hi   (hi_r),
        .acc_lo   (lo_r),
        .opnd     (opnd_r),
        .nxt_hi   (step_hi_s),
        .nxt_lo   (step_lo_s)
    );

    // Request decode: acceptance, operand signs/magnitudes and one-cycle special cases.
    always_comb begin
        op_in_s    = muldiv_op_t'(i_funct3);
        is_div_s   = i_funct3[2];
        accept_s   = i_start & ~i_flush & ((state_r == IDLE) | (state_r == DONE));
        sign1_s    = rs1_signed(op_in_s) & i_num1u[XLEN-1];
        sign2_s    = rs2_signed(op_in_s) & i_num2u[XLEN-1];
        mag1_s     = sign1_s ? (ZERO - i_num1u) : i_num1u;
        mag2_s     = sign2_s ? (ZERO - i_num2u) : i_num2u;
        div_zero_s = is_div_s & (i_num2u == ZERO);
        ovf_s      = ((op_in_s == OP_DIV) | (op_in_s == OP_REM)) &
                     (i_num1u == MOST_NEG) & (i_num2u == ALL_ONES);
        special_s  = div_zero_s | ovf_s;
        // funct3[1] separates REM/REMU from DIV/DIVU.
        if (div_zero_s) begin
            special_res_s = i_funct3[1] ? i_num1u : ALL_ONES;
        end else if (ovf_s) begin
            special_res_s = i_funct3[1] ? ZERO : i_num1u;
        end else begin
            special_res_s = ZERO;
        end
    end

    // Sign fix-up and result selection from the finished accumulator.
    always_comb begin
        prod_s = {hi_r[XLEN-1:0], lo_r};
        if (sign1_r ^ sign2_r) begin
            prod_s = {(2*XLEN){1'b0}} - prod_s;
        end else begin
            prod_s = prod_s;
        end
        quo_s = (sign1_r ^ sign2_r) ? (ZERO - lo_r) : lo_r;
        rem_s = sign1_r ? (ZERO - hi_r[XLEN-1:0]) : hi_r[XLEN-1:0];
        case (op_r)
            OP_MUL:                        fix_res_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res_s = quo_s;
            OP_REM, OP_REMU:               fix_res_s = rem_s;
            default:                       fix_res_s = ZERO;
        endcase
    end

    // Sequencer next state; flush overrides everything, including a new start.
    always_comb begin
        state_nxt_s = state_r;
        if (i_flush) begin
            state_nxt_s = IDLE;
        end else if (accept_s) begin
            state_nxt_s = special_s ? DONE : CALC;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = IDLE;
                CALC:    state_nxt_s = (cnt_r == CNT_ONE) ? FIX : CALC;
                FIX:     state_nxt_s = DONE;
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, status outputs and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            op_r    <= OP_MUL;
            sign1_r <= 1'b0;
            sign2_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            hi_r    <= {(XLEN+1){1'b0}};
            lo_r    <= ZERO;
            opnd_r  <= ZERO;
            res_r   <= ZERO;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == CALC) | (state_nxt_s == FIX);
            done_r  <= (state_nxt_s == DONE);
            if (accept_s) begin
                op_r    <= op_in_s;
                sign1_r <= sign1_s;
                sign2_r <= sign2_s;
                cnt_r   <= CNT_LOAD;
                hi_r    <= {(XLEN+1){1'b0}};
                // lo carries the bits to be consumed: multiplier or dividend.
                lo_r    <= is_div_s ? mag1_s : mag2_s;
                opnd_r  <= is_div_s ? mag2_s : mag1_s;
                if (special_s) begin
                    res_r <= special_res_s;
                end
            end else if ((state_r == CALC) && !i_flush) begin
                hi_r  <= step_hi_s;
                lo_r  <= step_lo_s;
                cnt_r <= cnt_r - CNT_ONE;
            end else if ((state_r == FIX) && !i_flush) begin
                res_r <= fix_res_s;
            end
        end
    end

    assign o_busy = busy_r;
    assign o_done = done_r;
    assign o_res  = res_r;

endmodule

// File: tb/tb_core_muldiv.sv
module tb_core_muldiv;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic        clk, rst;
    logic [1:0]  start_v, flush_v;
    logic [2:0]  f3_v [2];
    logic [31:0] a_v [2];
    logic [31:0] b_v [2];
    logic        busy0, busy1, done0, done1;
    logic [31:0] res0, res1;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          sp;
    } vec_t;
    vec_t vecs[$];

    core_muldiv #(.XLEN(32), .STEP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .i_start(start_v[0]), .i_funct3(f3_v[0]),
        .i_num1u(a_v[0]), .i_num2u(b_v[0]), .i_flush(flush_v[0]),
        .o_busy(busy0), .o_done(done0), .o_res(res0));

    core_muldiv #(.XLEN(32), .STEP_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .i_start(start_v[1]), .i_funct3(f3_v[1]),
        .i_num1u(a_v[1]), .i_num2u(b_v[1]), .i_flush(flush_v[1]),
        .o_busy(busy1), .o_done(done1), .o_res(res1));

    always #5 clk = ~clk;

    function automatic logic get_busy(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction
    function automatic logic get_done(input int d);
        return (d == 0) ? done0 : done1;
    endfunction
    function automatic logic [31:0] get_res(input int d);
        return (d == 0) ? res0 : res1;
    endfunction
    function automatic int n_iter(input int d);
        return (d == 0) ? 32 : 8;
    endfunction
    function automatic int sb(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic add_vec(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input bit sp);
        vec_t v;
        v.name = name; v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.sp = sp;
        vecs.push_back(v);
    endtask

    task automatic issue(input int d, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        start_v[d] = 1'b1;
        f3_v[d]    = f3;
        a_v[d]     = a;
        b_v[d]     = b;
    endtask

    // Called at a negedge; counts cycles (and busy cycles) until o_done, bounded.
    task automatic count_to_done(input int d, inout int lat, inout int busy_n);
        while (!get_done(d) && lat < 200) begin
            if (get_busy(d)) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    // Start is high in the current cycle; cycle 1 is the one after the accepting edge.
    task automatic begin_op(input int d, output int lat, output int busy_n);
        @(posedge clk);
        @(negedge clk);
        start_v[d] = 1'b0;
        lat = 1;
        busy_n = 0;
        count_to_done(d, lat, busy_n);
    endtask

    task automatic run_op(input int d, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat, output int busy_n);
        @(negedge clk);
        issue(d, f3, a, b);
        begin_op(d, lat, busy_n);
        res = get_res(d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int lat, busy_n, seen;
        string tag;

        clk = 1'b0; rst = 1'b1; start_v = 2'b00; flush_v = 2'b00;
        for (int d = 0; d < 2; d++) begin
            f3_v[d] = 3'b000; a_v[d] = 32'h0; b_v[d] = 32'h0;
        end
        pass_cnt = 0; total_cnt = 0;

        add_vec("MUL 7*-3",        F_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        add_vec("MUL 2^16*2^16",   F_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0);
        add_vec("MULH min*min",    F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        add_vec("MULH -1*1",       F_MULH,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        add_vec("MULHSU -1*max",   F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        add_vec("MULHU max*max",   F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        add_vec("MULHU 2^31*4",    F_MULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 1'b0);
        add_vec("DIV -7/2",        F_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);
        add_vec("REM -7/2",        F_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
        add_vec("DIV 7/-2",        F_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        add_vec("REM 7/-2",        F_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        add_vec("DIV min/2",       F_DIV,    32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 1'b0);
        add_vec("DIVU 100/7",      F_DIVU,   32'd100,       32'd7,         32'd14,        1'b0);
        add_vec("REMU 100/7",      F_REMU,   32'd100,       32'd7,         32'd2,         1'b0);
        add_vec("DIVU max/1",      F_DIVU,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        add_vec("REMU 2^31/2^31+1",F_REMU,   32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 1'b0);
        add_vec("DIVU 5/0",        F_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1);
        add_vec("REM 5/0",         F_REM,    32'd5,         32'd0,         32'd5,         1'b1);
        add_vec("REMU 100/0",      F_REMU,   32'd100,       32'd0,         32'd100,       1'b1);
        add_vec("DIV min/-1",      F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        add_vec("REM min/-1",      F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);

        // Reset state
        #12;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset busy sb%0d", sb(d)), 32'(get_busy(d)), 32'd0);
            check($sformatf("reset done sb%0d", sb(d)), 32'(get_done(d)), 32'd0);
            check($sformatf("reset res sb%0d",  sb(d)), get_res(d), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Vector table: result, latency and busy length on both step widths
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < vecs.size(); i++) begin
                run_op(d, vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, busy_n);
                tag = $sformatf("%s sb%0d", vecs[i].name, sb(d));
                check({tag, " res"}, res, vecs[i].exp);
                check({tag, " latency"}, 32'(lat), vecs[i].sp ? 32'd1 : 32'(n_iter(d) + 2));
                check({tag, " busy cycles"}, 32'(busy_n), vecs[i].sp ? 32'd0 : 32'(n_iter(d) + 1));
            end
        end

        for (int d = 0; d < 2; d++) begin
            // Back-to-back: new start issued in the DONE cycle
            run_op(d, F_MUL, 32'h7, 32'hFFFF_FFFD, res, lat, busy_n);
            check($sformatf("b2b first res sb%0d", sb(d)), res, 32'hFFFF_FFEB);
            issue(d, F_DIVU, 32'd100, 32'd7);
            begin_op(d, lat, busy_n);
            check($sformatf("b2b second res sb%0d", sb(d)), get_res(d), 32'd14);
            check($sformatf("b2b second latency sb%0d", sb(d)), 32'(lat), 32'(n_iter(d) + 2));

            // Start during CALC is ignored
            @(negedge clk);
            issue(d, F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            @(posedge clk);
            @(negedge clk);
            start_v[d] = 1'b0;
            lat = 1; busy_n = 0;
            repeat (3) begin @(negedge clk); lat++; end
            issue(d, F_DIVU, 32'd100, 32'd7);
            @(negedge clk); lat++;
            start_v[d] = 1'b0;
            count_to_done(d, lat, busy_n);
            check($sformatf("ignored start res sb%0d", sb(d)), get_res(d), 32'hFFFF_FFFE);
            check($sformatf("ignored start latency sb%0d", sb(d)), 32'(lat), 32'(n_iter(d) + 2));
            @(negedge clk);
            check($sformatf("ignored start no relaunch sb%0d", sb(d)), 32'(get_busy(d)), 32'd0);

            // Flush mid-CALC: back to IDLE, no done, result kept
            run_op(d, F_DIVU, 32'd100, 32'd7, res, lat, busy_n);
            @(negedge clk);
            issue(d, F_MUL, 32'h7, 32'hFFFF_FFFD);
            @(posedge clk);
            @(negedge clk);
            start_v[d] = 1'b0;
            lat = 1;
            while (lat < ((d == 0) ? 10 : 5)) begin @(negedge clk); lat++; end
            flush_v[d] = 1'b1;
            @(negedge clk);
            flush_v[d] = 1'b0;
            check($sformatf("flush busy sb%0d", sb(d)), 32'(get_busy(d)), 32'd0);
            seen = 0;
            repeat (40) begin
                if (get_done(d)) seen++;
                @(negedge clk);
            end
            check($sformatf("flush no done sb%0d", sb(d)), 32'(seen), 32'd0);
            check($sformatf("flush res kept sb%0d", sb(d)), get_res(d), 32'd14);

            // Flush beats a simultaneous start
            issue(d, F_MUL, 32'h7, 32'h3);
            flush_v[d] = 1'b1;
            @(negedge clk);
            start_v[d] = 1'b0;
            flush_v[d] = 1'b0;
            check($sformatf("flush+start busy sb%0d", sb(d)), 32'(get_busy(d)), 32'd0);
            seen = 0;
            repeat (12) begin
                if (get_done(d)) seen++;
                @(negedge clk);
            end
            check($sformatf("flush+start no done sb%0d", sb(d)), 32'(seen), 32'd0);
        end

        // Reset mid-CALC on both units: outputs clear without a clock edge
        @(negedge clk);
        issue(0, F_MUL, 32'h7, 32'hFFFF_FFFD);
        issue(1, F_MUL, 32'h7, 32'hFFFF_FFFD);
        @(posedge clk);
        @(negedge clk);
        start_v = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("async rst busy sb%0d", sb(d)), 32'(get_busy(d)), 32'd0);
            check($sformatf("async rst done sb%0d", sb(d)), 32'(get_done(d)), 32'd0);
            check($sformatf("async rst res sb%0d",  sb(d)), get_res(d), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            if (done0 || done1) seen++;
            @(negedge clk);
        end
        check("post-reset no done", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
